// File: rtl/data_memory_access_controller.sv
// Data memory access controller: arbitrates the single word-wide memory port
// between the MEM-stage core requester and a debug/loader requester, turns
// byte/halfword accesses into word accesses (read-modify-write for sub-word
// stores) and produces the pipeline stall.
module data_memory_access_controller #(
    parameter int data_bits = 32,
    parameter int addr_bits = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_read,
    input  logic                 core_write,
    input  logic [2:0]           core_funct3,
    input  logic [data_bits-1:0] core_addr,
    input  logic [data_bits-1:0] core_wdata,
    output logic [data_bits-1:0] core_rdata,
    output logic                 core_ack,
    output logic                 core_misaligned,
    output logic                 core_stall,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [addr_bits-1:0] dbg_addr,
    input  logic [data_bits-1:0] dbg_wdata,
    output logic [data_bits-1:0] dbg_rdata,
    output logic                 dbg_ack,
    output logic [addr_bits-1:0] mem_addr,
    output logic [data_bits-1:0] mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [data_bits-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, DATA, WR, DONE} state_t;

    // Owner encoding shared by owner_q and last_owner_q.
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_owner_q, last_owner_d;
    logic [addr_bits-1:0] addr_q, addr_d;
    logic [data_bits-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 mis_q, mis_d;
    logic [1:0]           boff_q, boff_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [data_bits-1:0] rdata_q, rdata_d;

    logic core_req;
    logic grant_dbg;
    logic core_mis;
    logic core_subword;

    // Extract the addressed byte/half from a memory word and extend it.
    // funct3[1:0]: 00 byte, 01 half, anything else a full word.
    function automatic logic [data_bits-1:0] load_extend(
        input logic [data_bits-1:0] word,
        input logic [1:0]           boff,
        input logic [2:0]           f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{boff, 3'b000} +: 8];
        h = word[{boff[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   load_extend = f3[2] ? {{(data_bits-8){1'b0}}, b}
                                         : {{(data_bits-8){b[7]}}, b};
            2'b01:   load_extend = f3[2] ? {{(data_bits-16){1'b0}}, h}
                                         : {{(data_bits-16){h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Merge the low byte/half of the store data into the word read back
    // from memory; untouched lanes keep their old contents.
    function automatic logic [data_bits-1:0] store_merge(
        input logic [data_bits-1:0] word,
        input logic [data_bits-1:0] wd,
        input logic [1:0]           boff,
        input logic [2:0]           f3
    );
        logic [data_bits-1:0] res;
        res = word;
        case (f3[1:0])
            2'b00:   res[{boff, 3'b000} +: 8] = wd[7:0];
            2'b01:   res[{boff[1], 4'b0000} +: 16] = wd[15:0];
            default: res = wd;
        endcase
        store_merge = res;
    endfunction

    assign core_req     = core_read | core_write;
    // Both pending: debug wins only if the core was the last owner.
    assign grant_dbg    = dbg_req & (~core_req | (last_owner_q == OWN_CORE));
    assign core_mis     = ((core_funct3[1:0] == 2'b01) & core_addr[0])
                        | (core_funct3[1] & (|core_addr[1:0]));
    assign core_subword = ~core_funct3[1];

    // Next-state logic: arbitration and request latching in IDLE, data
    // capture / store merge in DATA.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        mis_d        = mis_q;
        boff_d       = boff_q;
        funct3_d     = funct3_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_dbg) begin
                    owner_d      = OWN_DBG;
                    last_owner_d = OWN_DBG;
                    addr_d       = dbg_addr;
                    wdata_d      = dbg_wdata;
                    write_d      = dbg_we;
                    mis_d        = 1'b0;
                    boff_d       = 2'b00;
                    funct3_d     = 3'b010;
                    rdata_d      = '0;
                    state_d      = dbg_we ? WR : RD;
                end else if (core_req) begin
                    owner_d      = OWN_CORE;
                    last_owner_d = OWN_CORE;
                    addr_d       = core_addr[data_bits-1:2];
                    wdata_d      = core_wdata;
                    write_d      = core_write;
                    mis_d        = core_mis;
                    boff_d       = core_addr[1:0];
                    funct3_d     = core_funct3;
                    rdata_d      = '0;
                    if (core_mis) begin
                        state_d = DONE;
                    end else if (core_write && !core_subword) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = DATA;
            end
            DATA: begin
                if (write_q) begin
                    wdata_d = store_merge(mem_rdata, wdata_q, boff_q, funct3_q);
                    state_d = WR;
                end else begin
                    rdata_d = (owner_q == OWN_DBG) ? mem_rdata
                                                   : load_extend(mem_rdata, boff_q, funct3_q);
                    state_d = DONE;
                end
            end
            WR: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and the latches that drive the memory port directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CORE;
            last_owner_q <= OWN_DBG;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            mis_q        <= mis_d;
        end
    end

    // Access attributes and load result; only observed behind the acks.
    always_ff @(posedge clk) begin
        boff_q   <= boff_d;
        funct3_q <= funct3_d;
        rdata_q  <= rdata_d;
    end

    // Outputs decode from registered state and latches only, except the
    // stall which must react in the same cycle the request appears.
    always_comb begin
        mem_re          = (state_q == RD);
        mem_we          = (state_q == WR);
        mem_addr        = addr_q;
        mem_wdata       = wdata_q;
        core_ack        = (state_q == DONE) && (owner_q == OWN_CORE);
        dbg_ack         = (state_q == DONE) && (owner_q == OWN_DBG);
        core_rdata      = core_ack ? rdata_q : '0;
        dbg_rdata       = dbg_ack ? rdata_q : '0;
        core_misaligned = core_ack & mis_q;
        core_stall      = core_req & ~core_ack;
    end

endmodule

// File: tb/tb_data_memory_access_controller.sv
// Directed bench for data_memory_access_controller with a small word memory
// model and a scoreboard of expected load results.
module tb_data_memory_access_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_read, core_write;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_ack, core_misaligned, core_stall;
    logic        dbg_req, dbg_we;
    logic [29:0] dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    always #5 clk = ~clk;

    data_memory_access_controller #(.data_bits(32), .addr_bits(30)) dut (
        .clk(clk), .rst(rst),
        .core_read(core_read), .core_write(core_write), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_ack(core_ack), .core_misaligned(core_misaligned), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    // Word memory: registered read, write on the edge; preload port for the bench.
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int re_count = 0;
    int we_count = 0;
    int we_cyc_mark = 0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (mem_we) begin
            mem[mem_addr[5:0]] <= mem_wdata;
            we_count++;
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr[5:0]];
            re_count++;
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;

    int re_cyc, we_cyc, ack_cyc, re_n, we_n;
    logic [29:0] re_addr;
    logic stall_bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    // Issue one core access, wait (bounded) for its ack, compare against the
    // scoreboard entry pushed at issue time, then release the request.
    task automatic core_op(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_mis, input int exp_cyc);
        exp_t e;
        int   cyc;
        int   re0, we0;
        logic got;
        exp_q.push_back('{rdata: exp_rd, mis: exp_mis});
        re0 = re_count;
        we0 = we_count;
        core_read   = rd;
        core_write  = wr;
        core_funct3 = f3;
        core_addr   = a;
        core_wdata  = wd;
        #1;
        check({tag, "_stall_c0"}, {31'b0, core_stall}, 32'd1);
        cyc = 0; got = 1'b0; stall_bad = 1'b0; re_cyc = -1; we_cyc = -1;
        re_addr = '0;
        while (!got && cyc < 12) begin
            tick();
            cyc++;
            if (mem_re && re_cyc < 0) begin
                re_cyc  = cyc;
                re_addr = mem_addr;
            end
            if (mem_we && we_cyc < 0) we_cyc = cyc;
            if (core_ack) got = 1'b1;
            else if (core_stall !== 1'b1) stall_bad = 1'b1;
        end
        ack_cyc = cyc;
        e = exp_q.pop_front();
        check({tag, "_ack_cycle"}, ack_cyc, exp_cyc);
        check({tag, "_rdata"}, core_rdata, e.rdata);
        check({tag, "_mis"}, {31'b0, core_misaligned}, {31'b0, e.mis});
        check({tag, "_stall_at_ack"}, {31'b0, core_stall}, 32'd0);
        core_read  = 1'b0;
        core_write = 1'b0;
        tick();
        re_n = re_count - re0;
        we_n = we_count - we0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, c1, c2, d1, acks;
        logic got_dbg;

        rst = 1'b1;
        core_read = 0; core_write = 0; core_funct3 = 3'b010;
        core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        tick(); tick();

        // Reset state
        check("rst_core_ack", {31'b0, core_ack}, 32'd0);
        check("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
        check("rst_mem_re", {31'b0, mem_re}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", {2'b0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_rdata", core_rdata, 32'd0);
        check("rst_stall", {31'b0, core_stall}, 32'd0);
        rst = 1'b0;

        preload(6'd4,  32'hDEADBEEF);
        preload(6'd8,  32'h11223344);
        preload(6'd12, 32'h55667788);

        // LW 0x10 -> word 4
        core_op("lw", 1, 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 3);
        check("lw_re_cycle", re_cyc, 32'd1);
        check("lw_re_addr", {2'b0, re_addr}, 32'd4);
        check("lw_stall_hold", {31'b0, stall_bad}, 32'd0);
        check("lw_no_write", we_n, 32'd0);

        // Byte/half loads and extension
        preload(6'd4, 32'h80FF0000);
        core_op("lb",  1, 0, 3'b000, 32'h13, 0, 32'hFFFFFF80, 0, 3);
        core_op("lbu", 1, 0, 3'b100, 32'h13, 0, 32'h00000080, 0, 3);
        core_op("lh",  1, 0, 3'b001, 32'h12, 0, 32'hFFFF80FF, 0, 3);
        core_op("lhu", 1, 0, 3'b101, 32'h12, 0, 32'h000080FF, 0, 3);
        core_op("lb0", 1, 0, 3'b000, 32'h11, 0, 32'h00000000, 0, 3);
        // Unsupported funct3 behaves as a word load
        core_op("f3_011", 1, 0, 3'b011, 32'h10, 0, 32'h80FF0000, 0, 3);
        core_op("f3_110", 1, 0, 3'b110, 32'h10, 0, 32'h80FF0000, 0, 3);

        // SB 0x21 onto 0x11223344: RD, DATA, WR
        core_op("sb", 0, 1, 3'b000, 32'h21, 32'h000000AB, 0, 0, 4);
        check("sb_re_cycle", re_cyc, 32'd1);
        check("sb_we_cycle", we_cyc, 32'd3);
        check("sb_we_count", we_n, 32'd1);
        check("sb_mem", mem[8], 32'h1122AB44);

        // SH 0x22 onto 0x1122AB44
        core_op("sh", 0, 1, 3'b001, 32'h22, 32'hFFFF1234, 0, 0, 4);
        check("sh_mem", mem[8], 32'h1234AB44);

        // Misaligned accesses: ack in one cycle, no memory traffic
        core_op("lw_mis", 1, 0, 3'b010, 32'h02, 0, 32'h0, 1, 1);
        check("lw_mis_re", re_n, 32'd0);
        check("lw_mis_we", we_n, 32'd0);
        core_op("lh_mis", 1, 0, 3'b001, 32'h05, 0, 32'h0, 1, 1);
        core_op("sh_mis", 0, 1, 3'b001, 32'h23, 32'h5555, 32'h0, 1, 1);
        check("sh_mis_we", we_n, 32'd0);
        check("sh_mis_mem", mem[8], 32'h1234AB44);

        // Collision after a fresh reset: core first, then debug, then core
        rst = 1'b1; tick(); rst = 1'b0;
        core_write = 1; core_funct3 = 3'b010; core_addr = 32'h40; core_wdata = 32'hA5A50001;
        dbg_req = 1; dbg_we = 1; dbg_addr = 30'd20; dbg_wdata = 32'h0D0D0002;
        cyc = 0; c1 = -1; c2 = -1; d1 = -1;
        while ((c2 < 0 || d1 < 0) && cyc < 20) begin
            tick();
            cyc++;
            if (core_ack) begin
                if (c1 < 0) begin
                    c1 = cyc;
                    // Next store presented right away: collides with debug.
                    core_addr  = 32'h44;
                    core_wdata = 32'hC3C30003;
                end else begin
                    c2 = cyc;
                    core_write = 0;
                end
            end
            if (dbg_ack) begin
                d1 = cyc;
                dbg_req = 0;
            end
        end
        tick();
        check("col_core1_ack", c1, 32'd2);
        check("col_dbg_ack", d1, 32'd5);
        check("col_core2_ack", c2, 32'd8);
        check("col_mem16", mem[16], 32'hA5A50001);
        check("col_mem20", mem[20], 32'h0D0D0002);
        check("col_mem17", mem[17], 32'hC3C30003);

        // Debug word read
        dbg_req = 1; dbg_we = 0; dbg_addr = 30'd16;
        cyc = 0; got_dbg = 1'b0;
        while (!got_dbg && cyc < 12) begin
            tick();
            cyc++;
            if (dbg_ack) got_dbg = 1'b1;
        end
        check("dbg_rd_ack", cyc, 32'd3);
        check("dbg_rd_data", dbg_rdata, 32'hA5A50001);
        check("dbg_rd_core_ack", {31'b0, core_ack}, 32'd0);
        dbg_req = 0;
        tick();

        // Reset during DATA of a sub-word store aborts it
        re_cyc = re_count;
        we_cyc_mark = we_count;
        core_write = 1; core_funct3 = 3'b000; core_addr = 32'h31; core_wdata = 32'hEE;
        tick();
        check("abort_rd", {31'b0, mem_re}, 32'd1);
        tick();
        rst = 1'b1; core_write = 0;
        tick();
        rst = 1'b0;
        check("abort_idle_re", {31'b0, mem_re}, 32'd0);
        check("abort_idle_we", {31'b0, mem_we}, 32'd0);
        check("abort_idle_addr", {2'b0, mem_addr}, 32'd0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (core_ack) acks++;
            tick();
        end
        check("abort_no_ack", acks, 32'd0);
        check("abort_no_write", we_count - we_cyc_mark, 32'd0);
        check("abort_mem", mem[12], 32'h55667788);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
